// File: rtl/wifi_viterbi_pkg.sv
// Shared definitions for the K=7, rate-1/2 hard-decision Viterbi decoder.
// Contents:
//   K, NSTATE        constraint length and trellis size
//   G0, G1           generator polynomials (133o, 171o)
//   fsm_t            decoder control states
//   branch_out()     coded pair {B,A} emitted when bit b leaves state s
//   hamming2()       population count of a 2-bit difference
package wifi_viterbi_pkg;

    localparam int         K      = 7;
    localparam int         NSTATE = 1 << (K - 1);
    localparam logic [6:0] G0     = 7'o133;
    localparam logic [6:0] G1     = 7'o171;

    typedef enum logic {
        RUN   = 1'b0,
        FLUSH = 1'b1
    } fsm_t;

    // r = {b, state}: r[6] is the current bit, r[6-k] the bit delayed by k.
    // The polynomial masks select exactly those taps.
    function automatic logic [1:0] branch_out(input logic [5:0] state, input logic b);
        logic [6:0] r;
        r = {b, state};
        return {^(r & G1), ^(r & G0)};
    endfunction

    function automatic logic [1:0] hamming2(input logic [1:0] diff);
        return {diff[1] & diff[0], diff[1] ^ diff[0]};
    endfunction

endpackage

// File: rtl/viterbi_decoder_k7_if.sv
// Symbol-in / bit-out bus of the Viterbi decoder.
// Signals:
//   in_valid, in_ready, in_sym[1:0] ([0]=A, [1]=B), in_last  -- coded symbol stream
//   out_valid, out_bit, out_last                           -- decoded bit stream
// Handshake: a symbol transfers on a rising edge where in_valid and in_ready
// are both high; while in_ready is low the source holds in_sym/in_last
// stable with in_valid asserted. The output side has no ready: every cycle
// with out_valid high delivers one bit, oldest first.
interface viterbi_decoder_k7_if;
    logic       in_valid;
    logic       in_ready;
    logic [1:0] in_sym;
    logic       in_last;
    logic       out_valid;
    logic       out_bit;
    logic       out_last;

    modport master (
        output in_valid, in_sym, in_last,
        input  in_ready, out_valid, out_bit, out_last
    );

    modport slave (
        input  in_valid, in_sym, in_last,
        output in_ready, out_valid, out_bit, out_last
    );
endinterface

// File: rtl/viterbi_acs_unit.sv
// Add-compare-select for one next state of the trellis.
// Ports:
//   pm0, pm1    path metrics of the two predecessors (p0 = {ns[4:0],0}, p1 = {ns[4:0],1})
//   bm0, bm1    branch metrics (0..2) of the transitions p0->ns, p1->ns
//   pm_out      surviving metric
//   decision    1 when p1 survives; ties keep p0
module viterbi_acs_unit #(
    parameter int METRIC_W = 8
) (
    input  logic [METRIC_W-1:0] pm0,
    input  logic [METRIC_W-1:0] pm1,
    input  logic [1:0]          bm0,
    input  logic [1:0]          bm1,
    output logic [METRIC_W-1:0] pm_out,
    output logic                decision
);
    logic [METRIC_W-1:0] cand0;
    logic [METRIC_W-1:0] cand1;

    // Normalisation keeps every metric well below the top of the range,
    // so these sums cannot carry out.
    assign cand0    = pm0 + METRIC_W'(bm0);
    assign cand1    = pm1 + METRIC_W'(bm1);
    assign decision = (cand1 < cand0);
    assign pm_out   = decision ? cand1 : cand0;
endmodule

// File: rtl/viterbi_decoder_k7.sv
// Hard-decision Viterbi decoder, K=7 rate-1/2 (g0=133o, g1=171o).
// 64 parallel ACS units, register-exchange survivors, output taken from
// state 0 (frames are terminated by 6 zero tail bits).
// Ports:
//   clk        rising-edge clock
//   rst        asynchronous active-low reset
//   bus        slave side of viterbi_decoder_k7_if (symbols in, bits out)
//   fsm_state  current control state, for observation
module viterbi_decoder_k7
    import wifi_viterbi_pkg::*;
#(
    parameter int TB_DEPTH = 48,
    parameter int METRIC_W = 8
) (
    input  logic                clk,
    input  logic                rst,
    viterbi_decoder_k7_if.slave bus,
    output fsm_t                fsm_state
);
    localparam int                  CNT_W    = $clog2(TB_DEPTH + 1);
    localparam logic [METRIC_W-1:0] PM_BIAS  = {2'b01, {(METRIC_W - 2){1'b0}}};
    localparam logic [CNT_W-1:0]    CNT_MAX  = CNT_W'(TB_DEPTH);
    localparam logic [CNT_W-1:0]    CNT_EMIT = CNT_W'(TB_DEPTH - 1);

    fsm_t                state_q;
    fsm_t                state_d;
    logic [CNT_W-1:0]    sym_cnt_q;
    logic [CNT_W-1:0]    idx_q;
    logic                run_out_q;
    logic [METRIC_W-1:0] pm_q     [NSTATE];
    logic [TB_DEPTH-1:0] surv_q   [NSTATE];
    logic [METRIC_W-1:0] pm_acs   [NSTATE];
    logic [METRIC_W-1:0] pm_norm  [NSTATE];
    logic [TB_DEPTH-1:0] surv_acs [NSTATE];
    logic [NSTATE-1:0]   dec;
    logic [NSTATE-1:0]   msb;
    logic                all_msb;
    logic                accept;
    logic                in_ready;
    logic                out_valid;
    logic                out_bit;
    logic                out_last;

    // ---------------------------------------------------------------- trellis
    for (genvar ns = 0; ns < NSTATE; ns++) begin : g_acs
        localparam logic [5:0] NS = 6'(ns);
        localparam logic [5:0] P0 = {NS[4:0], 1'b0};
        localparam logic [5:0] P1 = {NS[4:0], 1'b1};

        logic [1:0]          bm0;
        logic [1:0]          bm1;
        logic [TB_DEPTH-1:0] prev;

        // The bit that drives any transition into ns is ns[5].
        assign bm0 = hamming2(bus.in_sym ^ branch_out(P0, NS[5]));
        assign bm1 = hamming2(bus.in_sym ^ branch_out(P1, NS[5]));

        viterbi_acs_unit #(.METRIC_W(METRIC_W)) u_acs (
            .pm0      (pm_q[P0]),
            .pm1      (pm_q[P1]),
            .bm0      (bm0),
            .bm1      (bm1),
            .pm_out   (pm_acs[ns]),
            .decision (dec[ns])
        );

        assign prev         = dec[ns] ? surv_q[P1] : surv_q[P0];
        assign surv_acs[ns] = {prev[TB_DEPTH-2:0], NS[5]};
        assign msb[ns]      = pm_acs[ns][METRIC_W-1];
        // Dropping a common MSB subtracts the same constant from every
        // metric, so all comparisons are unchanged.
        assign pm_norm[ns]  = all_msb ? {1'b0, pm_acs[ns][METRIC_W-2:0]} : pm_acs[ns];
    end

    assign all_msb = &msb;

    // ---------------------------------------------------------------- control
    always_comb begin
        state_d   = state_q;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        out_bit   = 1'b0;
        out_last  = 1'b0;
        case (state_q)
            RUN: begin
                in_ready  = 1'b1;
                out_valid = run_out_q;
                out_bit   = run_out_q & surv_q[0][TB_DEPTH-1];
                if (accept && bus.in_last) begin
                    state_d = FLUSH;
                end
            end
            FLUSH: begin
                out_valid = 1'b1;
                out_bit   = surv_q[0][idx_q];
                out_last  = (idx_q == '0);
                if (idx_q == '0) begin
                    state_d = RUN;
                end
            end
            default: state_d = RUN;
        endcase
    end

    assign accept        = bus.in_valid & in_ready;
    assign bus.in_ready  = in_ready;
    assign bus.out_valid = out_valid;
    assign bus.out_bit   = out_bit;
    assign bus.out_last  = out_last;
    assign fsm_state     = state_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= RUN;
            sym_cnt_q <= '0;
            idx_q     <= '0;
            run_out_q <= 1'b0;
            for (int i = 0; i < NSTATE; i++) begin
                pm_q[i]   <= (i == 0) ? '0 : PM_BIAS;
                surv_q[i] <= '0;
            end
        end else begin
            state_q   <= state_d;
            run_out_q <= 1'b0;
            if (accept) begin
                for (int i = 0; i < NSTATE; i++) begin
                    pm_q[i]   <= pm_norm[i];
                    surv_q[i] <= surv_acs[i];
                end
                if (sym_cnt_q != CNT_MAX) begin
                    sym_cnt_q <= sym_cnt_q + 1'b1;
                end
                if (bus.in_last) begin
                    // The bit a non-final accept would have emitted next cycle
                    // is folded into the flush, so flush starts at the oldest
                    // not-yet-emitted bit: index (saturated count after this
                    // symbol) - 1.
                    idx_q <= (sym_cnt_q == CNT_MAX) ? CNT_EMIT : sym_cnt_q;
                end else begin
                    run_out_q <= (sym_cnt_q >= CNT_EMIT);
                end
            end
            if (state_q == FLUSH) begin
                if (idx_q == '0) begin
                    sym_cnt_q <= '0;
                    for (int i = 0; i < NSTATE; i++) begin
                        pm_q[i]   <= (i == 0) ? '0 : PM_BIAS;
                        surv_q[i] <= '0;
                    end
                end else begin
                    idx_q <= idx_q - 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_viterbi_decoder_k7.sv
// Self-checking bench for viterbi_decoder_k7.
// The reference is the information sequence itself: a clean or lightly
// corrupted codeword must decode back to its source bits, oldest first,
// with out_last on the final bit of each frame.
module tb_viterbi_decoder_k7;
    import wifi_viterbi_pkg::*;

    localparam int TB_DEPTH  = 48;
    localparam int METRIC_W  = 8;
    localparam int NOISE_LEN = 10000;

    logic clk;
    logic rst;
    fsm_t fsm_state;

    viterbi_decoder_k7_if bus ();

    viterbi_decoder_k7 #(
        .TB_DEPTH (TB_DEPTH),
        .METRIC_W (METRIC_W)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .bus       (bus),
        .fsm_state (fsm_state)
    );

    // ------------------------------------------------------ clock / reset
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // ------------------------------------------------------ bookkeeping
    int         checks = 0;
    int         errors = 0;
    logic [2:0] exp_q[$];        // {care, last, bit}
    int         frame_len_q[$];
    logic       src_bits[$];
    logic [1:0] tx_syms[$];

    int         cyc            = 0;
    int         acc_in_frame   = 0;
    int         last_last_cyc  = -1000;
    int         gap_after_last = 0;
    int         low_run        = 0;
    int         last_low_run   = 0;
    int         held_cycles    = 0;
    int         run_outs       = 0;
    bit         first_out      = 1'b1;
    logic [2:0] e;
    int         exp_lat;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp_v);
        checks++;
        if (act !== exp_v) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp_v, $time);
        end
    endtask

    // ------------------------------------------------------ encoder model
    // hist[k] is the information bit delayed by k symbols.
    function automatic logic [1:0] enc_sym(input logic [6:0] hist);
        logic a;
        logic b;
        a = hist[0] ^ hist[2] ^ hist[3] ^ hist[5] ^ hist[6];
        b = hist[0] ^ hist[1] ^ hist[2] ^ hist[3] ^ hist[6];
        return {b, a};
    endfunction

    task automatic encode_from(input int start);
        logic [6:0] hist;
        hist = '0;
        for (int i = start; i < src_bits.size(); i++) begin
            hist = {hist[5:0], src_bits[i]};
            tx_syms.push_back(enc_sym(hist));
        end
    endtask

    task automatic add_random(input int n);
        for (int i = 0; i < n; i++) src_bits.push_back(1'($urandom_range(0, 1)));
    endtask

    task automatic add_zeros(input int n);
        for (int i = 0; i < n; i++) src_bits.push_back(1'b0);
    endtask

    task automatic new_frame();
        src_bits.delete();
        tx_syms.delete();
    endtask

    // ------------------------------------------------------ scoreboard feed
    task automatic queue_frame(input int n, input int care_from);
        for (int i = 0; i < n; i++) begin
            exp_q.push_back({(i >= care_from), (i == n - 1), src_bits[i]});
        end
        frame_len_q.push_back(n);
    endtask

    // ------------------------------------------------------ driver tasks
    task automatic send_sym(input logic [1:0] s, input logic last);
        int   waited;
        logic acc;
        waited       = 0;
        acc          = 1'b0;
        bus.in_valid = 1'b1;
        bus.in_sym   = s;
        bus.in_last  = last;
        while (!acc && waited <= 200) begin
            @(negedge clk);
            acc = bus.in_ready;
            @(posedge clk);
            #1;
            if (!acc) waited++;
        end
        if (!acc) begin
            checks++;
            errors++;
            $display("FAIL accept_timeout: symbol not accepted after %0d cycles, expected within 200", waited);
        end
        bus.in_valid = 1'b0;
        bus.in_last  = 1'b0;
        bus.in_sym   = 2'b00;
    endtask

    task automatic run_frame(input int n, input int care_from, input bit gaps, input bit push);
        if (push) queue_frame(n, care_from);
        for (int i = 0; i < n; i++) begin
            if (gaps && $urandom_range(0, 7) == 0) begin
                @(posedge clk);
                #1;
            end
            send_sym(tx_syms[i], (i == n - 1));
        end
    endtask

    task automatic wait_drain();
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < 3000) begin
            @(posedge clk);
            n++;
        end
        if (exp_q.size() != 0) begin
            checks++;
            errors++;
            $display("FAIL drain: %0d bits still pending, expected 0", exp_q.size());
            exp_q.delete();
            frame_len_q.delete();
        end
        repeat (60) @(posedge clk);
        #1;
    endtask

    // ------------------------------------------------------ compare process
    always @(negedge clk) begin
        if (!rst) begin
            acc_in_frame = 0;
            first_out    = 1'b1;
            low_run      = 0;
        end else begin
            if (bus.out_last && !bus.out_valid) begin
                check("out_last_without_valid", 1, 0);
            end
            if (bus.out_valid) begin
                if (bus.in_ready) run_outs++;
                if (exp_q.size() == 0) begin
                    check("extra_output_bit", 1, 0);
                end else begin
                    e = exp_q.pop_front();
                    if (first_out) begin
                        first_out = 1'b0;
                        exp_lat   = (frame_len_q.size() != 0) ? frame_len_q.pop_front() : 0;
                        check("first_out_after_symbols", acc_in_frame,
                              (exp_lat < TB_DEPTH) ? exp_lat : TB_DEPTH);
                    end
                    check("decoded_last_bit",
                          {30'd0, bus.out_last, e[2] ? bus.out_bit : 1'b0},
                          {30'd0, e[1], e[2] ? e[0] : 1'b0});
                    if (bus.out_last) begin
                        first_out     = 1'b1;
                        acc_in_frame  = 0;
                        last_last_cyc = cyc;
                    end
                end
            end
            if (bus.in_valid && bus.in_ready) begin
                if (acc_in_frame == 0) gap_after_last = cyc - last_last_cyc;
                acc_in_frame++;
            end
            if (bus.in_valid && !bus.in_ready) held_cycles++;
            if (!bus.in_ready) begin
                low_run++;
            end else if (low_run != 0) begin
                last_low_run = low_run;
                low_run      = 0;
            end
        end
        cyc++;
    end

    // ------------------------------------------------------ watchdog
    initial begin
        #900_000;
        $display("FAIL watchdog: simulation still running at %0t, expected to finish earlier", $time);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors + 1);
        $fatal(1, "watchdog expired");
    end

    // ------------------------------------------------------ stimulus
    logic [63:0] known_vec;
    int          n_frame;

    initial begin
        bus.in_valid = 1'b0;
        bus.in_sym   = 2'b00;
        bus.in_last  = 1'b0;
        rst          = 1'b0;
        known_vec    = 64'hB3A1_5C7E_0F96_2D48;

        // Reset state.
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("reset_in_ready", bus.in_ready, 1);
        check("reset_out_valid", bus.out_valid, 0);
        check("reset_out_bit", bus.out_bit, 0);
        check("reset_out_last", bus.out_last, 0);
        check("reset_fsm", fsm_state, RUN);
        @(posedge clk);
        #1 rst = 1'b1;

        // Pin the encoder model: impulse response and 1101.
        new_frame();
        src_bits.push_back(1'b1);
        add_zeros(6);
        encode_from(0);
        check("enc_impulse_0", tx_syms[0], 3);
        check("enc_impulse_1", tx_syms[1], 2);
        check("enc_impulse_2", tx_syms[2], 3);
        check("enc_impulse_3", tx_syms[3], 3);
        check("enc_impulse_4", tx_syms[4], 0);
        check("enc_impulse_5", tx_syms[5], 1);
        check("enc_impulse_6", tx_syms[6], 3);
        new_frame();
        src_bits.push_back(1'b1);
        src_bits.push_back(1'b1);
        src_bits.push_back(1'b0);
        src_bits.push_back(1'b1);
        encode_from(0);
        check("enc_1101_0", tx_syms[0], 3);
        check("enc_1101_1", tx_syms[1], 1);
        check("enc_1101_2", tx_syms[2], 1);
        check("enc_1101_3", tx_syms[3], 3);

        // 1. Zero frame.
        new_frame();
        add_zeros(100);
        encode_from(0);
        run_frame(100, 0, 1'b0, 1'b1);
        wait_drain();

        // 2. Known vector with zero tail.
        new_frame();
        for (int i = 0; i < 64; i++) src_bits.push_back(known_vec[63 - i]);
        add_zeros(6);
        encode_from(0);
        run_frame(70, 0, 1'b0, 1'b1);
        wait_drain();

        // 3. Error correction: one flipped coded bit every 20 symbols.
        new_frame();
        add_random(500);
        add_zeros(6);
        encode_from(0);
        for (int i = 19; i < tx_syms.size(); i += 20) begin
            tx_syms[i] = tx_syms[i] ^ (((i / 20) % 2 == 1) ? 2'b10 : 2'b01);
        end
        run_frame(506, 0, 1'b1, 1'b1);
        wait_drain();

        // 4. Short frame: output only during flush, in_ready low for 10 cycles.
        new_frame();
        src_bits.push_back(1'b1);
        src_bits.push_back(1'b0);
        src_bits.push_back(1'b1);
        src_bits.push_back(1'b1);
        add_zeros(6);
        encode_from(0);
        run_outs = 0;
        run_frame(10, 0, 1'b0, 1'b1);
        wait_drain();
        check("short_in_ready_low_cycles", last_low_run, 10);
        check("short_outputs_while_ready", run_outs, 0);

        // 5. Back-to-back frames with in_valid held through the flush.
        new_frame();
        add_random(14);
        add_zeros(6);
        encode_from(0);
        held_cycles = 0;
        run_frame(20, 0, 1'b0, 1'b1);
        new_frame();
        add_random(24);
        add_zeros(6);
        encode_from(0);
        run_frame(30, 0, 1'b0, 1'b1);
        check("b2b_first_accept_after_last", gap_after_last, 1);
        wait_drain();
        check("b2b_held_cycles", held_cycles, 20);

        // 6. Long all-ones noise then a clean segment in the same frame.
        new_frame();
        add_zeros(NOISE_LEN);
        add_random(200);
        add_zeros(6);
        for (int i = 0; i < NOISE_LEN; i++) tx_syms.push_back(2'b11);
        encode_from(NOISE_LEN);
        n_frame = src_bits.size();
        run_frame(n_frame, NOISE_LEN + 80, 1'b0, 1'b1);
        wait_drain();

        // Reset asserted at symbol 30 of a frame.
        new_frame();
        add_random(54);
        add_zeros(6);
        encode_from(0);
        for (int i = 0; i < 30; i++) send_sym(tx_syms[i], 1'b0);
        rst = 1'b0;
        @(negedge clk);
        check("abort_out_valid", bus.out_valid, 0);
        check("abort_out_bit", bus.out_bit, 0);
        check("abort_out_last", bus.out_last, 0);
        check("abort_in_ready", bus.in_ready, 1);
        check("abort_fsm", fsm_state, RUN);
        @(posedge clk);
        #1 rst = 1'b1;

        // Clean frame after the abort.
        new_frame();
        add_random(74);
        add_zeros(6);
        encode_from(0);
        run_frame(80, 0, 1'b1, 1'b1);
        wait_drain();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
